// File: rtl/rbot_pkg.sv
// Shared cube-robot definitions: move codes, face indices and executor states.
// Used by the move executor and the move sequencer.
package rbot_pkg;

  localparam int NUM_FACES = 6;

  typedef logic [3:0] move_code_t;

  localparam move_code_t MOVE_NONE     = 4'd0;
  localparam move_code_t MOVE_CW_FIRST = 4'd1;
  localparam move_code_t MOVE_CW_LAST  = 4'd6;
  localparam move_code_t MOVE_CCW_LAST = 4'd12;

  typedef enum logic [2:0] {
    FACE_U, FACE_D, FACE_F, FACE_B, FACE_L, FACE_R
  } face_t;

  typedef enum logic [2:0] {
    IDLE, SETUP, STEP_HIGH, STEP_LOW, SETTLE, DONE
  } exec_state_t;

  function automatic logic is_turn(move_code_t code);
    return (code >= MOVE_CW_FIRST) && (code <= MOVE_CCW_LAST);
  endfunction

  // Clockwise codes 1-6 and counter-clockwise codes 7-12 map onto the same faces.
  function automatic face_t face_of(move_code_t code);
    move_code_t idx;
    idx = (code <= MOVE_CW_LAST) ? code - MOVE_CW_FIRST : code - (MOVE_CW_LAST + MOVE_CW_FIRST);
    return face_t'(idx[2:0]);
  endfunction

  function automatic logic [NUM_FACES-1:0] face_mask(face_t f);
    return {{(NUM_FACES-1){1'b0}}, 1'b1} << f;
  endfunction

  function automatic int unsigned at_least_one(int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Down-counting delay timer: load a count, decrement to zero, flag expiry.
module step_timer
  import rbot_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic        expired
);

  logic [31:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 32'd1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/move_executor.sv
// Executes one quarter-turn move: drives the selected face's stepper through
// dir setup, STEPS_PER_QUARTER step pulses and a mechanical settle, then reports done.
module move_executor
  import rbot_pkg::*;
#(
  parameter int unsigned STEPS_PER_QUARTER = 50,
  parameter int unsigned HALF_PERIOD       = 50000,
  parameter int unsigned SETUP_CYCLES      = 100,
  parameter int unsigned SETTLE_CYCLES     = 1000000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [3:0]           next_move,
  input  logic                 start_move,
  output logic [NUM_FACES-1:0] step,
  output logic [NUM_FACES-1:0] dir,
  output logic [NUM_FACES-1:0] motor_en,
  output logic                 busy,
  output logic                 move_done,
  output logic                 illegal_move
);

  localparam int unsigned STEP_COUNT = at_least_one(STEPS_PER_QUARTER);
  localparam int unsigned HALF_LEN   = at_least_one(HALF_PERIOD);
  localparam int unsigned SETUP_LEN  = at_least_one(SETUP_CYCLES);
  localparam int unsigned SETTLE_LEN = at_least_one(SETTLE_CYCLES);

  exec_state_t state;
  face_t       face;
  logic [15:0] steps_left;
  logic        illegal_pending;
  logic        timer_load;
  logic [31:0] timer_value;
  logic        timer_expired;

  step_timer u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // Each timed state is entered with length-1 loaded, so it lasts exactly length cycles.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE: if (start_move && is_turn(next_move)) begin
        timer_load  = 1'b1;
        timer_value = SETUP_LEN - 1;
      end
      SETUP, STEP_HIGH: if (timer_expired) begin
        timer_load  = 1'b1;
        timer_value = HALF_LEN - 1;
      end
      STEP_LOW: if (timer_expired) begin
        timer_load  = 1'b1;
        timer_value = (steps_left == 16'd1) ? SETTLE_LEN - 1 : HALF_LEN - 1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      face            <= FACE_U;
      steps_left      <= '0;
      illegal_pending <= 1'b0;
      step            <= '0;
      dir             <= '0;
      motor_en        <= '0;
      busy            <= 1'b0;
      move_done       <= 1'b0;
      illegal_move    <= 1'b0;
    end else begin
      move_done    <= 1'b0;
      illegal_move <= 1'b0;
      case (state)
        IDLE: if (start_move) begin
          busy <= 1'b1;
          if (is_turn(next_move)) begin
            face       <= face_of(next_move);
            dir        <= (next_move <= MOVE_CW_LAST) ? face_mask(face_of(next_move)) : '0;
            motor_en   <= face_mask(face_of(next_move));
            steps_left <= 16'(STEP_COUNT);
            state      <= SETUP;
          end else begin
            illegal_pending <= (next_move != MOVE_NONE);
            state           <= DONE;
          end
        end
        SETUP: if (timer_expired) begin
          step  <= face_mask(face);
          state <= STEP_HIGH;
        end
        STEP_HIGH: if (timer_expired) begin
          step  <= '0;
          state <= STEP_LOW;
        end
        STEP_LOW: if (timer_expired) begin
          steps_left <= steps_left - 16'd1;
          if (steps_left == 16'd1) begin
            state <= SETTLE;
          end else begin
            step  <= face_mask(face);
            state <= STEP_HIGH;
          end
        end
        SETTLE: if (timer_expired) state <= DONE;
        DONE: begin
          move_done       <= 1'b1;
          illegal_move    <= illegal_pending;
          illegal_pending <= 1'b0;
          busy            <= 1'b0;
          motor_en        <= '0;
          dir             <= '0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
